// File: rtl/vlc_subcarrier_mapper.sv
// vlc_subcarrier_mapper
//   Collects the 1, 2 or 4 payload words of one OFDM symbol, maps them onto
//   32 data subcarriers (BPSK / QPSK / Gray 16-QAM) and streams one 64-bin
//   frequency-domain frame, in natural bin order, to the IFFT input.
//
// Ports
//   aclk, areset           clock, synchronous active-high reset
//   s_axis_*               payload words in (tlast is checked only)
//   mod_type               0 BPSK, 1 QPSK, 2/3 16-QAM (latched on the first word)
//   m_axis_*               {Q[15:0], I[15:0]} samples out, tlast on bin 63
//   done_tick              1-cycle pulse after the bin-63 handshake
//   frame_err              1-cycle pulse after a word whose tlast was wrong
//
// Build option
//   VLC_MAPPER_PILOT_EN    when defined, bins 17 and 47 carry I=+8192, Q=0.
//                          When undefined they are zero guard bins.

module vlc_subcarrier_mapper (
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic [1:0]  mod_type,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        done_tick,
    output logic        frame_err
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT} state_t;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] i;
    } iq_t;

    // Constellation amplitudes (16-bit two's complement)
    localparam logic [15:0] A_BPSK_P = 16'h2000;  // +8192
    localparam logic [15:0] A_BPSK_N = 16'hE000;  // -8192
    localparam logic [15:0] A_QPSK_P = 16'h16A1;  // +5793
    localparam logic [15:0] A_QPSK_N = 16'hE95F;  // -5793
    localparam logic [15:0] A_QAM_P3 = 16'h1E5C;  // +7772
    localparam logic [15:0] A_QAM_P1 = 16'h0A1F;  // +2591
    localparam logic [15:0] A_QAM_N1 = 16'hF5E1;  // -2591
    localparam logic [15:0] A_QAM_N3 = 16'hE1A4;  // -7772

    state_t            state, state_nxt;
    logic [1:0]        mod_q;
    logic [1:0]        wcnt;
    logic [3:0][31:0]  word_buf;    // word_buf[0] holds bits 31:0 of the stream
    logic [5:0]        bin;
    logic [31:0]       tdata_q;
    logic              tlast_q;
    logic              done_q;
    logic              ferr_q;

    logic              in_hs, out_hs;
    logic [1:0]        cur_mod, cur_idx;
    logic              word_is_last;
    logic [5:0]        bin_nxt;
    iq_t               sample_nxt;

    // Index of the final word for a modulation: N-1 with N = 1, 2, 4
    function automatic logic [1:0] last_word_idx(input logic [1:0] m);
        case (m)
            2'd0:    last_word_idx = 2'd0;
            2'd1:    last_word_idx = 2'd1;
            default: last_word_idx = 2'd3;
        endcase
    endfunction

    // Gray 16-QAM level for a bit pair {msb, lsb}
    function automatic logic [15:0] qam_level(input logic [1:0] b);
        case (b)
            2'b00:   qam_level = A_QAM_N3;
            2'b01:   qam_level = A_QAM_N1;
            2'b11:   qam_level = A_QAM_P1;
            default: qam_level = A_QAM_P3;
        endcase
    endfunction

    // Sample for bin n. Bins 1..16 carry d = 0..15, bins 48..63 carry
    // d = 16..31; every other bin is zero apart from the optional pilots.
    function automatic iq_t map_sample(input logic [127:0] bits,
                                       input logic [1:0]   m,
                                       input logic [5:0]   n);
        iq_t        s;
        logic [4:0] d;
        logic       data_bin;
        s        = '0;
        data_bin = ((n >= 6'd1) && (n <= 6'd16)) || (n >= 6'd48);
        // For n in 48..63, n-32 is simply n[4:0]
        d        = (n <= 6'd16) ? (n[4:0] - 5'd1) : n[4:0];
        if (data_bin) begin
            case (m)
                2'd0: begin
                    s.i = bits[{2'b00, d}] ? A_BPSK_P : A_BPSK_N;
                end
                2'd1: begin
                    s.i = bits[{1'b0, d, 1'b0}]        ? A_QPSK_P : A_QPSK_N;
                    s.q = bits[{1'b0, d, 1'b0} + 7'd1] ? A_QPSK_P : A_QPSK_N;
                end
                default: begin
                    s.i = qam_level(bits[{d, 2'b00} +: 2]);
                    s.q = qam_level(bits[{d, 2'b10} +: 2]);
                end
            endcase
        end
`ifdef VLC_MAPPER_PILOT_EN
        if ((n == 6'd17) || (n == 6'd47)) begin
            s.i = A_BPSK_P;
            s.q = '0;
        end
`endif
        return s;
    endfunction

    assign in_hs  = s_axis_tvalid & s_axis_tready;
    assign out_hs = m_axis_tvalid & m_axis_tready;

    // In S_IDLE the word in flight is word 0 of a frame whose modulation is
    // still on the input; afterwards the latched copy governs.
    assign cur_mod      = (state == S_IDLE) ? mod_type : mod_q;
    assign cur_idx      = (state == S_IDLE) ? 2'd0 : wcnt;
    assign word_is_last = (cur_idx == last_word_idx(cur_mod));

    assign bin_nxt    = bin + 6'd1;
    assign sample_nxt = map_sample(word_buf, mod_q, bin_nxt);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge aclk) begin
        if (areset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_hs) state_nxt = word_is_last ? S_EMIT : S_LOAD;
            S_LOAD:  if (in_hs && word_is_last) state_nxt = S_EMIT;
            S_EMIT:  if (out_hs && (bin == 6'd63)) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Every output is forced low while reset is held, including the
    // cycle in which reset is first raised.
    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        if (!areset) begin
            s_axis_tready = (state == S_IDLE) || (state == S_LOAD);
            m_axis_tvalid = (state == S_EMIT);
        end
    end

    assign m_axis_tdata = areset ? '0 : tdata_q;
    assign m_axis_tlast = areset ? 1'b0 : tlast_q;
    assign done_tick    = areset ? 1'b0 : done_q;
    assign frame_err    = areset ? 1'b0 : ferr_q;

    // ---------------- datapath ----------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            mod_q    <= '0;
            wcnt     <= '0;
            word_buf <= '0;
            bin      <= '0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            done_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ferr_q <= 1'b0;

            if (in_hs) begin
                word_buf[cur_idx] <= s_axis_tdata;
                ferr_q            <= (s_axis_tlast != word_is_last);
                if (state == S_IDLE) mod_q <= mod_type;
                wcnt <= word_is_last ? 2'd0 : (cur_idx + 2'd1);
                if (word_is_last) begin
                    // Bin 0 is DC and always zero, so the first sample
                    // does not depend on the word being written now.
                    bin     <= '0;
                    tdata_q <= '0;
                    tlast_q <= 1'b0;
                end
            end

            if (out_hs) begin
                if (bin == 6'd63) begin
                    bin     <= '0;
                    done_q  <= 1'b1;
                    tdata_q <= '0;
                    tlast_q <= 1'b0;
                end else begin
                    bin     <= bin_nxt;
                    tdata_q <= sample_nxt;
                    tlast_q <= (bin_nxt == 6'd63);
                end
            end
        end
    end

endmodule
